fu_md_iter: RTL and testbench



---
 rtl/md_types.sv | 28 ++
 rtl/md_div_iter.sv | 78 +++++++
 rtl/fu_md_iter.sv | 202 ++++++++++++++++++++
 tb/tb_fu_md_iter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_types.sv
// Shared types for the iterative multiply/divide unit: funct3-aligned opcodes,
// FSM states and opcode bit positions.
package md_types;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

    // Bit 2 selects divide ops; within divides, bit 1 selects remainder and bit 0 unsigned.
    localparam int MD_OP_IS_DIV = 2;
    localparam int MD_OP_IS_REM = 1;
    localparam int MD_OP_IS_UNS = 0;

endpackage

// File: rtl/md_div_iter.sv
// Radix-2 restoring divider core on unsigned magnitudes: one quotient bit per
// cycle, XLEN cycles after start, then done is held for one cycle.
module md_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CNT_W = $clog2(XLEN + 1);

    logic            busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN:0]   trial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
        end
    end

    assign done = busy_q && (cnt_q == CNT_W'(XLEN));

    // quo_q shifts the dividend out at the top while quotient bits enter at the bottom.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        trial  = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
        if (flush) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            quo_d  = dividend;
            rem_d  = '0;
            dvs_d  = divisor;
        end else if (done) begin
            busy_d = 1'b0;
        end else if (busy_q) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!trial[XLEN]) begin
                rem_d = trial[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/fu_md_iter.sv
// RV M-extension functional unit: fixed-latency multiply, iterative divide.
// Optional FU_MD_DIV_EARLY_OUT_EN: trivial divides finish one cycle after accept.
module fu_md_iter
    import md_types::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2,
    parameter int PRF_IDX_W  = 6,
    parameter int ROB_IDX_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 prv_valid,
    output logic                 prv_ready,
    input  logic [2:0]           fu_opcode,
    input  logic [XLEN-1:0]      rs1_value,
    input  logic [XLEN-1:0]      rs2_value,
    input  logic [PRF_IDX_W-1:0] rd_phy,
    input  logic [ROB_IDX_W-1:0] rob_id,
    output logic                 nxt_valid,
    input  logic                 nxt_ready,
    output logic [XLEN-1:0]      out_data,
    output logic [PRF_IDX_W-1:0] out_rd_phy,
    output logic [ROB_IDX_W-1:0] out_rob_id
);

    localparam int MUL_CNT_W = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
    localparam logic [XLEN-1:0] X_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t            state_q, state_d;
    logic [MUL_CNT_W-1:0] mul_cnt_q, mul_cnt_d;
    md_op_t               op_q, op_d;
    logic [XLEN-1:0]      rs1_q, rs1_d, rs2_q, rs2_d;
    logic                 a_neg_q, a_neg_d, b_neg_q, b_neg_d, early_q, early_d;
    logic [XLEN-1:0]      out_data_q, out_data_d;
    logic [PRF_IDX_W-1:0] out_rd_phy_q, out_rd_phy_d;
    logic [ROB_IDX_W-1:0] out_rob_id_q, out_rob_id_d;

    logic                 accept, in_is_div, in_signed, in_a_neg, in_b_neg, in_early;
    logic [XLEN-1:0]      in_mag_a, in_mag_b;
    logic                 div_start, div_done;
    logic [XLEN-1:0]      div_quo, div_rem;
    logic                 mul_sa, mul_sb, div_ovf;
    logic [2*XLEN-1:0]    mul_a, mul_b, mul_p;
    logic [XLEN-1:0]      mul_res, div_q_res, div_r_res, div_res;

    assign accept    = prv_valid && prv_ready;
    assign in_is_div = fu_opcode[MD_OP_IS_DIV];
    assign in_signed = !fu_opcode[MD_OP_IS_UNS];
    assign in_a_neg  = in_is_div && in_signed && rs1_value[XLEN-1];
    assign in_b_neg  = in_is_div && in_signed && rs2_value[XLEN-1];
    assign in_mag_a  = in_a_neg ? -rs1_value : rs1_value;
    assign in_mag_b  = in_b_neg ? -rs2_value : rs2_value;

`ifdef FU_MD_DIV_EARLY_OUT_EN
    assign in_early = (rs2_value == '0)
                   || (in_signed && rs1_value == X_MIN && rs2_value == '1)
                   || (in_mag_a < in_mag_b);
`else
    assign in_early = 1'b0;
`endif

    assign div_start = accept && in_is_div && !in_early;

    md_div_iter #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .start     (div_start),
        .dividend  (in_mag_a),
        .divisor   (in_mag_b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Sign-extend to 2*XLEN so one unsigned multiply covers all four signedness mixes.
    always_comb begin
        mul_sa  = (op_q == MD_MULH) || (op_q == MD_MULHSU);
        mul_sb  = (op_q == MD_MULH);
        mul_a   = {{XLEN{mul_sa & rs1_q[XLEN-1]}}, rs1_q};
        mul_b   = {{XLEN{mul_sb & rs2_q[XLEN-1]}}, rs2_q};
        mul_p   = mul_a * mul_b;
        mul_res = (op_q == MD_MUL) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
    end

    always_comb begin
        div_ovf = !op_q[MD_OP_IS_UNS] && (rs1_q == X_MIN) && (rs2_q == '1);
        if (rs2_q == '0) begin
            div_q_res = '1;
            div_r_res = rs1_q;
        end else if (div_ovf) begin
            div_q_res = rs1_q;
            div_r_res = '0;
        end else if (early_q) begin
            div_q_res = '0;
            div_r_res = rs1_q;
        end else begin
            div_q_res = (a_neg_q ^ b_neg_q) ? -div_quo : div_quo;
            div_r_res = a_neg_q ? -div_rem : div_rem;
        end
        div_res = op_q[MD_OP_IS_REM] ? div_r_res : div_q_res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mul_cnt_q    <= '0;
            op_q         <= MD_MUL;
            rs1_q        <= '0;
            rs2_q        <= '0;
            a_neg_q      <= 1'b0;
            b_neg_q      <= 1'b0;
            early_q      <= 1'b0;
            out_data_q   <= '0;
            out_rd_phy_q <= '0;
            out_rob_id_q <= '0;
        end else begin
            state_q      <= state_d;
            mul_cnt_q    <= mul_cnt_d;
            op_q         <= op_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            a_neg_q      <= a_neg_d;
            b_neg_q      <= b_neg_d;
            early_q      <= early_d;
            out_data_q   <= out_data_d;
            out_rd_phy_q <= out_rd_phy_d;
            out_rob_id_q <= out_rob_id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) state_d = in_is_div ? ST_DIV : ST_MUL;
                ST_MUL:  if (mul_cnt_q == MUL_CNT_W'(MUL_STAGES - 1)) state_d = ST_DONE;
                ST_DIV:  if (early_q || div_done) state_d = ST_DONE;
                ST_DONE: begin
                    if (accept)         state_d = in_is_div ? ST_DIV : ST_MUL;
                    else if (nxt_ready) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Tags are captured at accept; out_data is written only on entry to DONE.
    always_comb begin
        mul_cnt_d    = mul_cnt_q;
        op_d         = op_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        a_neg_d      = a_neg_q;
        b_neg_d      = b_neg_q;
        early_d      = early_q;
        out_data_d   = out_data_q;
        out_rd_phy_d = out_rd_phy_q;
        out_rob_id_d = out_rob_id_q;
        if (flush) begin
            mul_cnt_d = '0;
            early_d   = 1'b0;
        end else begin
            if (accept) begin
                op_d         = md_op_t'(fu_opcode);
                rs1_d        = rs1_value;
                rs2_d        = rs2_value;
                a_neg_d      = in_a_neg;
                b_neg_d      = in_b_neg;
                early_d      = in_is_div && in_early;
                mul_cnt_d    = '0;
                out_rd_phy_d = rd_phy;
                out_rob_id_d = rob_id;
            end
            if (state_q == ST_MUL) begin
                if (mul_cnt_q == MUL_CNT_W'(MUL_STAGES - 1)) begin
                    mul_cnt_d  = '0;
                    out_data_d = mul_res;
                end else begin
                    mul_cnt_d = mul_cnt_q + MUL_CNT_W'(1);
                end
            end
            if (state_q == ST_DIV && (early_q || div_done)) begin
                out_data_d = div_res;
            end
        end
    end

    always_comb begin
        prv_ready = !flush && ((state_q == ST_IDLE) || (state_q == ST_DONE && nxt_ready));
        nxt_valid = (state_q == ST_DONE);
    end

    assign out_data   = out_data_q;
    assign out_rd_phy = out_rd_phy_q;
    assign out_rob_id = out_rob_id_q;

endmodule

// File: tb/tb_fu_md_iter.sv
// Scoreboard bench for fu_md_iter: directed M-extension cases, random ops,
// DONE back-pressure, flush and mid-operation reset.
module tb_fu_md_iter;

    localparam int XLEN = 32;
    localparam int MS   = 2;
`ifdef FU_MD_DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam logic [31:0] X_MIN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n, flush, prv_valid, prv_ready, nxt_valid, nxt_ready;
    logic [2:0]  fu_opcode;
    logic [31:0] rs1_value, rs2_value, out_data;
    logic [5:0]  rd_phy, out_rd_phy;
    logic [4:0]  rob_id, out_rob_id;

    fu_md_iter #(.XLEN(XLEN), .MUL_STAGES(MS), .PRF_IDX_W(6), .ROB_IDX_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .prv_valid(prv_valid), .prv_ready(prv_ready),
        .fu_opcode(fu_opcode), .rs1_value(rs1_value), .rs2_value(rs2_value),
        .rd_phy(rd_phy), .rob_id(rob_id), .nxt_valid(nxt_valid), .nxt_ready(nxt_ready),
        .out_data(out_data), .out_rd_phy(out_rd_phy), .out_rob_id(out_rob_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        logic [5:0]  rd;
        logic [4:0]  rob;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   seen    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] r;
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (a == X_MIN && b == 32'hFFFF_FFFF) ? a
                      : 32'($signed(a) / $signed(b));
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : (a == X_MIN && b == 32'hFFFF_FFFF) ? 32'h0
                      : 32'($signed(a) % $signed(b));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic        sgn;
        logic [31:0] ma, mb;
        if (!op[2]) return MS;
        sgn = !op[0];
        ma  = (sgn && a[31]) ? -a : a;
        mb  = (sgn && b[31]) ? -b : b;
        if (EARLY && (b == 0 || (sgn && a == X_MIN && b == 32'hFFFF_FFFF) || ma < mb)) return 1;
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return X_MIN;
            4: return 32'($urandom_range(0, 100));
            default: return $urandom;
        endcase
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit   done;
        exp_t e;
        fu_opcode = op;
        rs1_value = a;
        rs2_value = b;
        rd_phy    = 6'($urandom);
        rob_id    = 5'($urandom);
        prv_valid = 1'b1;
        done      = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (prv_ready) begin
                e.op   = op;
                e.data = model(op, a, b);
                e.rd   = rd_phy;
                e.rob  = rob_id;
                e.acc  = cyc + 1;
                e.lat  = latency(op, a, b);
                sb.push_back(e);
                done   = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        prv_valid = 1'b0;
        if (!done) check("issue_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && nxt_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", 64'd1, 64'd0);
                end else begin
                    if (!seen) begin
                        check($sformatf("latency op%0d", sb[0].op), 64'(cyc - sb[0].acc), 64'(sb[0].lat));
                        seen = 1'b1;
                    end
                    if (nxt_ready) begin
                        check($sformatf("data op%0d", sb[0].op), 64'(out_data), 64'(sb[0].data));
                        check("rd_phy", 64'(out_rd_phy), 64'(sb[0].rd));
                        check("rob_id", 64'(out_rob_id), 64'(sb[0].rob));
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          any_valid;
        logic [31:0] hold_val;
        rst_n = 1'b0; flush = 1'b0; prv_valid = 1'b0; nxt_ready = 1'b1;
        fu_opcode = '0; rs1_value = '0; rs2_value = '0; rd_phy = '0; rob_id = '0;
        #12;
        check("rst_nxt_valid", 64'(nxt_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_rd", 64'(out_rd_phy), 64'd0);
        check("rst_out_rob", 64'(out_rob_id), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_prv_ready", 64'(prv_ready), 64'd1);

        // Directed cases
        issue(3'd0, 32'd5, 32'd3);
        issue(3'd1, 32'hFFFF_FFFF, 32'h39);
        issue(3'd2, 32'hFFFF_FFFF, 32'h39);
        issue(3'd3, 32'hFFFF_FFFF, 32'h39);
        issue(3'd2, 32'h39, 32'hFFFF_FFFF);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2);
        issue(3'd5, 32'd7, 32'd0);
        issue(3'd7, 32'd7, 32'd0);
        issue(3'd4, X_MIN, 32'hFFFF_FFFF);
        issue(3'd6, X_MIN, 32'hFFFF_FFFF);
        issue(3'd4, 32'd0, 32'd0);
        issue(3'd6, 32'hFFFF_FFF9, 32'd0);
        issue(3'd5, 32'd3, 32'd10);
        issue(3'd6, 32'hFFFF_FFFB, 32'd9);
        issue(3'd7, 32'hFFFF_FFFF, 32'd16);
        wait_idle();

        // Random ops, issued back to back
        for (int i = 0; i < 24; i++) issue(3'($urandom_range(0, 7)), pick(), pick());
        wait_idle();

        // Back-pressure in DONE, then retire and accept on the same edge
        nxt_ready = 1'b0;
        issue(3'd0, 32'd6, 32'd7);
        for (int i = 0; i < 20 && !nxt_valid; i++) @(negedge clk);
        check("hold_reached", 64'(nxt_valid), 64'd1);
        hold_val = out_data;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_data", 64'(out_data), 64'd42);
            check("hold_stable", 64'(out_data), 64'(hold_val));
            check("hold_prv_ready", 64'(prv_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        nxt_ready = 1'b1;
        issue(3'd0, 32'd9, 32'd9);
        check("b2b_pending", 64'(sb.size()), 64'd1);
        wait_idle();

        // Flush ten cycles into a divide; an op offered in the flush cycle is dropped
        issue(3'd4, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        prv_valid = 1'b1;
        fu_opcode = 3'd0;
        @(negedge clk);
        check("flush_prv_ready", 64'(prv_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        prv_valid = 1'b0;
        sb.delete();
        seen = 1'b0;
        @(negedge clk);
        check("flush_nxt_valid", 64'(nxt_valid), 64'd0);
        check("flush_idle", 64'(prv_ready), 64'd1);
        any_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            any_valid |= nxt_valid;
        end
        check("flush_no_result", 64'(any_valid), 64'd0);

        // Asynchronous reset in the middle of a multiply
        @(posedge clk);
        #1;
        issue(3'd0, 32'd3, 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(nxt_valid), 64'd0);
        check("mid_rst_data", 64'(out_data), 64'd0);
        check("mid_rst_rd", 64'(out_rd_phy), 64'd0);
        check("mid_rst_rob", 64'(out_rob_id), 64'd0);
        sb.delete();
        seen = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        any_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            any_valid |= nxt_valid;
        end
        check("rst_no_result", 64'(any_valid), 64'd0);

        @(posedge clk);
        #1;
        issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
